// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-back, write-allocate cache controller over a 128x56 single-port SRAM.
// Latency: a hit responds 2 cycles after accept; a miss adds optional victim write-back plus refill.
// Backpressure: one request in flight, req_ready_o stays low until rsp_ready_i takes the response.
module cache_ctrl #(
   parameter int AWidth = 29,
   parameter int Depth  = 128,
   parameter int DWidth = 56,
   parameter int Index  = $clog2(Depth)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [AWidth-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_rdata_o,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic              mem_req_we_o,
   output logic [AWidth-1:0] mem_req_addr_o,
   output logic [31:0]       mem_req_wdata_o,
   input  logic              mem_rsp_valid_i,
   input  logic [31:0]       mem_rsp_rdata_i,
   output logic              sram_csb_o,
   output logic              sram_oeb_o,
   output logic              sram_web_o,
   output logic [Index-1:0]  sram_addr_o,
   output logic [DWidth-1:0] sram_wdata_o,
   input  logic [DWidth-1:0] sram_rdata_i,
   output logic              init_done_o
);

   localparam int TWidth = AWidth - Index;

   typedef enum logic [2:0] {
      INIT, IDLE, COMPARE, WB, REFILL_REQ, REFILL_WAIT, FILL, RESP
   } state_t;

   state_t              state;
   logic [Index-1:0]    cnt;
   logic                lat_we;
   logic [AWidth-1:0]   lat_addr;
   logic [31:0]         lat_wdata;
   logic [31:0]         refill_data;
   logic [TWidth-1:0]   lat_tag;
   logic [Index-1:0]    lat_idx;
   logic                hit;
   logic                victim_dirty;

   assign lat_tag      = lat_addr[AWidth-1:Index];
   assign lat_idx      = lat_addr[Index-1:0];
   // Line layout: [55] valid, [54] dirty, [53:32] tag, [31:0] data.
   assign hit          = sram_rdata_i[DWidth-1] && (sram_rdata_i[DWidth-3:32] == lat_tag);
   assign victim_dirty = sram_rdata_i[DWidth-1] && sram_rdata_i[DWidth-2];

   // SRAM strobes decoded from state; held idle until the first clock after reset
   // releases (sram_oeb_o doubles as the "just left reset" flag).
   always_comb begin
      sram_csb_o   = 1'b1;
      sram_web_o   = 1'b1;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      if (!sram_oeb_o) begin
         case (state)
            INIT: begin
               sram_csb_o  = 1'b0;
               sram_web_o  = 1'b0;
               sram_addr_o = cnt;
            end
            IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  sram_csb_o  = 1'b0;
                  sram_addr_o = req_addr_i[Index-1:0];
               end
            end
            COMPARE: begin
               if (lat_we && hit) begin
                  sram_csb_o   = 1'b0;
                  sram_web_o   = 1'b0;
                  sram_addr_o  = lat_idx;
                  sram_wdata_o = {2'b11, lat_tag, lat_wdata};
               end
            end
            FILL: begin
               sram_csb_o   = 1'b0;
               sram_web_o   = 1'b0;
               sram_addr_o  = lat_idx;
               sram_wdata_o = {1'b1, lat_we, lat_tag, lat_we ? lat_wdata : refill_data};
            end
            default: ;
         endcase
      end
   end

   // Controller FSM with registered handshake and memory-port outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state           <= INIT;
         cnt             <= '0;
         sram_oeb_o      <= 1'b1;
         init_done_o     <= 1'b0;
         req_ready_o     <= 1'b0;
         rsp_valid_o     <= 1'b0;
         rsp_rdata_o     <= '0;
         mem_req_valid_o <= 1'b0;
         mem_req_we_o    <= 1'b0;
         mem_req_addr_o  <= '0;
         mem_req_wdata_o <= '0;
         lat_we          <= 1'b0;
         lat_addr        <= '0;
         lat_wdata       <= '0;
         refill_data     <= '0;
      end else begin
         sram_oeb_o <= 1'b0;
         case (state)
            INIT: begin
               // The first cycle out of reset only clears the reset flag.
               if (!sram_oeb_o) begin
                  cnt <= cnt + Index'(1);
                  if (cnt == Index'(Depth - 1)) begin
                     state       <= IDLE;
                     init_done_o <= 1'b1;
                     req_ready_o <= 1'b1;
                  end
               end
            end
            IDLE: begin
               if (req_valid_i) begin
                  lat_we      <= req_we_i;
                  lat_addr    <= req_addr_i;
                  lat_wdata   <= req_wdata_i;
                  req_ready_o <= 1'b0;
                  state       <= COMPARE;
               end
            end
            COMPARE: begin
               if (hit) begin
                  rsp_rdata_o <= lat_we ? lat_wdata : sram_rdata_i[31:0];
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else if (victim_dirty) begin
                  mem_req_valid_o <= 1'b1;
                  mem_req_we_o    <= 1'b1;
                  mem_req_addr_o  <= {sram_rdata_i[DWidth-3:32], lat_idx};
                  mem_req_wdata_o <= sram_rdata_i[31:0];
                  state           <= WB;
               end else if (lat_we) begin
                  state <= FILL;
               end else begin
                  mem_req_valid_o <= 1'b1;
                  mem_req_we_o    <= 1'b0;
                  mem_req_addr_o  <= lat_addr;
                  state           <= REFILL_REQ;
               end
            end
            WB: begin
               if (mem_req_ready_i) begin
                  if (lat_we) begin
                     mem_req_valid_o <= 1'b0;
                     state           <= FILL;
                  end else begin
                     // Refill request follows straight on as a fresh transfer.
                     mem_req_we_o   <= 1'b0;
                     mem_req_addr_o <= lat_addr;
                     state          <= REFILL_REQ;
                  end
               end
            end
            REFILL_REQ: begin
               if (mem_req_ready_i) begin
                  mem_req_valid_o <= 1'b0;
                  state           <= REFILL_WAIT;
               end
            end
            REFILL_WAIT: begin
               if (mem_rsp_valid_i) begin
                  refill_data <= mem_rsp_rdata_i;
                  state       <= FILL;
               end
            end
            FILL: begin
               rsp_rdata_o <= lat_we ? lat_wdata : refill_data;
               rsp_valid_o <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule
